// File: rtl/svm_linear_mc.sv
// Multi-class linear SVM scorer: streams in NCLS weight vectors with biases,
// then scores one feature vector per class on a single MAC and reports the arg-max.
module svm_linear_mc #(
    parameter  int FEAT = 11,
    parameter  int NCLS = 1,
    parameter  int WW   = 9,
    parameter  int XW   = 2,
    localparam int CLW  = (NCLS > 1) ? $clog2(NCLS) : 1,
    localparam int AW   = WW + XW + $clog2(FEAT + 1) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           write1,
    input  logic [WW-1:0]  SVMin,
    input  logic           write2,
    input  logic [XW-1:0]  datain,
    output logic           ready,
    output logic           wvalid,
    output logic           done,
    output logic           result,
    output logic [CLW-1:0] cls_out,
    output logic [AW-1:0]  score
);

    localparam int NW = NCLS * (FEAT + 1);
    localparam int PW = $clog2(NW);
    localparam int FW = $clog2(FEAT + 1);

    localparam logic [PW-1:0]  PLAST = PW'(NW - 1);
    localparam logic [FW-1:0]  FLAST = FW'(FEAT - 1);
    localparam logic [FW-1:0]  FEND  = FW'(FEAT);
    localparam logic [CLW-1:0] CLAST = CLW'(NCLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_LOADX,
        S_WAIT,
        S_CALC,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [PW-1:0]         ptr_q;
    logic [FW-1:0]         fidx_q;
    logic [CLW-1:0]        cidx_q;
    logic [CLW-1:0]        bcls_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  best_q;

    logic [WW-1:0]         cmem_q [NW];
    logic [XW-1:0]         xmem_q [FEAT+1];

    logic                  w_acc;
    logic                  x_acc;
    logic [PW-1:0]         waddr;
    logic [FW-1:0]         xaddr;
    logic signed [WW-1:0]  w_s;
    logic signed [XW-1:0]  x_s;
    logic signed [AW-1:0]  w_ext;
    logic signed [AW-1:0]  x_ext;
    logic signed [AW-1:0]  prod_d;
    logic signed [AW-1:0]  sc_d;

    // write1 has priority over write2 when both arrive in IDLE
    assign w_acc = write1 && (state_q == S_IDLE || state_q == S_LOADW);
    assign x_acc = write2 && ((state_q == S_IDLE && wvalid && !write1)
                              || state_q == S_LOADX);
    assign waddr = (state_q == S_IDLE) ? '0 : ptr_q;
    assign xaddr = (state_q == S_IDLE) ? '0 : fidx_q;

    assign w_s    = cmem_q[ptr_q];
    assign x_s    = xmem_q[fidx_q];
    assign w_ext  = AW'(w_s);
    assign x_ext  = AW'(x_s);
    assign prod_d = w_ext * x_ext;
    assign sc_d   = acc_q + w_ext;

    always_ff @(posedge clk) begin
        if (w_acc) cmem_q[waddr] <= SVMin;
        if (x_acc) xmem_q[xaddr] <= datain;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            fidx_q  <= '0;
            cidx_q  <= '0;
            bcls_q  <= '0;
            acc_q   <= '0;
            best_q  <= '0;
            ready   <= 1'b1;
            wvalid  <= 1'b0;
            done    <= 1'b0;
            result  <= 1'b0;
            cls_out <= '0;
            score   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (write1) begin
                        state_q <= S_LOADW;
                        wvalid  <= 1'b0;
                        ready   <= 1'b0;
                        ptr_q   <= PW'(1);
                    end else if (write2 && wvalid) begin
                        ready <= 1'b0;
                        if (FEAT == 1) begin
                            state_q <= start ? S_CALC : S_WAIT;
                            fidx_q  <= '0;
                        end else begin
                            state_q <= S_LOADX;
                            fidx_q  <= FW'(1);
                        end
                    end
                end
                S_LOADW: begin
                    if (write1) begin
                        if (ptr_q == PLAST) begin
                            ptr_q   <= '0;
                            wvalid  <= 1'b1;
                            ready   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            ptr_q <= ptr_q + PW'(1);
                        end
                    end
                end
                S_LOADX: begin
                    if (write2) begin
                        if (fidx_q == FLAST) begin
                            fidx_q  <= '0;
                            state_q <= start ? S_CALC : S_WAIT;
                        end else begin
                            fidx_q <= fidx_q + FW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (start) state_q <= S_CALC;
                end
                S_CALC: begin
                    // ptr_q walks the coefficient RAM linearly; the last word of a class is its bias
                    if (fidx_q == FEND) begin
                        fidx_q <= '0;
                        acc_q  <= '0;
                        if (cidx_q == '0 || sc_d > best_q) begin
                            best_q <= sc_d;
                            bcls_q <= cidx_q;
                        end
                        if (cidx_q == CLAST) begin
                            cidx_q  <= '0;
                            ptr_q   <= '0;
                            state_q <= S_DONE;
                        end else begin
                            cidx_q <= cidx_q + CLW'(1);
                            ptr_q  <= ptr_q + PW'(1);
                        end
                    end else begin
                        fidx_q <= fidx_q + FW'(1);
                        ptr_q  <= ptr_q + PW'(1);
                        acc_q  <= acc_q + prod_d;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    ready   <= 1'b1;
                    score   <= best_q;
                    result  <= ~best_q[AW-1];
                    cls_out <= bcls_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_linear_mc.sv
// Directed bench for svm_linear_mc: default (11x1) and a 3-feature, 2-class instance.
module tb_svm_linear_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_start, a_w1, a_w2;
    logic [8:0]  a_svm;
    logic [1:0]  a_din;
    logic        a_ready, a_wvalid, a_done, a_result;
    logic [0:0]  a_cls;
    logic [15:0] a_score;

    logic        b_start, b_w1, b_w2;
    logic [8:0]  b_svm;
    logic [1:0]  b_din;
    logic        b_ready, b_wvalid, b_done, b_result;
    logic [0:0]  b_cls;
    logic [13:0] b_score;

    int nrun = 0;
    int nfail = 0;
    int wbuf [32];
    int xbuf [16];
    int lat;

    svm_linear_mc #(.FEAT(11), .NCLS(1), .WW(9), .XW(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start),
        .write1(a_w1), .SVMin(a_svm), .write2(a_w2), .datain(a_din),
        .ready(a_ready), .wvalid(a_wvalid), .done(a_done),
        .result(a_result), .cls_out(a_cls), .score(a_score)
    );

    svm_linear_mc #(.FEAT(3), .NCLS(2), .WW(9), .XW(2)) u_b (
        .clk(clk), .rst(rst), .start(b_start),
        .write1(b_w1), .SVMin(b_svm), .write2(b_w2), .datain(b_din),
        .ready(b_ready), .wvalid(b_wvalid), .done(b_done),
        .result(b_result), .cls_out(b_cls), .score(b_score)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        nrun++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic a_loadw(input int n, input int pause_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == pause_at) begin
                a_w1 = 1'b0;
                repeat (5) @(negedge clk);
            end
            a_w1  = 1'b1;
            a_svm = 9'(wbuf[i]);
        end
        @(negedge clk);
        a_w1 = 1'b0;
    endtask

    task automatic a_feed(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_w2  = 1'b1;
            a_din = 2'(xbuf[i]);
        end
        @(posedge clk);
        #1 a_w2 = 1'b0;
    endtask

    task automatic a_wait(output int l);
        l = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (a_done) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic a_nodone(input int n, input string tag);
        int seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (a_done) seen++;
        end
        chk(tag, seen, 0);
    endtask

    task automatic b_loadw(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b_w1  = 1'b1;
            b_svm = 9'(wbuf[i]);
        end
        @(negedge clk);
        b_w1 = 1'b0;
    endtask

    task automatic b_feed(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b_w2  = 1'b1;
            b_din = 2'(xbuf[i]);
        end
        @(posedge clk);
        #1;
        b_w2    = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic b_wait(output int l);
        l = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (b_done) begin
                l = k;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        a_start = 0; a_w1 = 0; a_w2 = 0; a_svm = '0; a_din = '0;
        b_start = 0; b_w1 = 0; b_w2 = 0; b_svm = '0; b_din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst ready", a_ready, 1);
        chk("rst wvalid", a_wvalid, 0);
        chk("rst done", a_done, 0);
        chk("rst result", a_result, 0);
        chk("rst cls", a_cls, 0);
        chk("rst score", a_score, 0);
        chk("rst b ready", b_ready, 1);
        @(negedge clk) rst = 1'b1;

        @(negedge clk);
        a_w2 = 1'b1; a_din = 2'd1;
        @(negedge clk) a_w2 = 1'b0;
        @(posedge clk);
        #1;
        chk("w2 no coef ready", a_ready, 1);
        chk("w2 no coef wvalid", a_wvalid, 0);

        for (int i = 0; i < 11; i++) wbuf[i] = 1;
        wbuf[11] = -3;
        a_loadw(12, 4);
        @(posedge clk);
        #1;
        chk("load wvalid", a_wvalid, 1);
        chk("load ready", a_ready, 1);
        for (int i = 0; i < 11; i++) xbuf[i] = (i < 3) ? 1 : 0;
        a_start = 1'b1;
        a_feed(11);
        a_wait(lat);
        chk("dflt latency", lat, 13);
        chk("dflt score", $signed(a_score), 0);
        chk("dflt result", a_result, 1);
        chk("dflt cls", a_cls, 0);
        @(posedge clk);
        #1 chk("dflt done pulse", a_done, 0);

        for (int i = 0; i < 11; i++) wbuf[i] = -256;
        wbuf[11] = 255;
        a_loadw(12, -1);
        for (int i = 0; i < 11; i++) xbuf[i] = -2;
        a_start = 1'b0;
        a_feed(11);
        a_nodone(10, "wait hold");
        chk("wait ready", a_ready, 0);
        @(negedge clk) a_start = 1'b1;
        @(posedge clk);
        a_wait(lat);
        chk("ext latency", lat, 13);
        chk("ext score", $signed(a_score), 5887);
        chk("ext result", a_result, 1);

        wbuf[0] = 1;  wbuf[1] = 2; wbuf[2] = 3; wbuf[3] = -4;
        wbuf[4] = -1; wbuf[5] = 0; wbuf[6] = 5; wbuf[7] = 0;
        b_loadw(8);
        xbuf[0] = 1; xbuf[1] = 1; xbuf[2] = 1;
        b_start = 1'b1;
        b_feed(3);
        b_wait(lat);
        chk("mc latency", lat, 9);
        chk("mc score", $signed(b_score), 4);
        chk("mc cls", b_cls, 1);
        chk("mc result", b_result, 1);

        xbuf[0] = -1; xbuf[1] = -1; xbuf[2] = -1;
        b_start = 1'b1;
        b_feed(3);
        b_wait(lat);
        chk("mc neg latency", lat, 9);
        chk("mc neg score", $signed(b_score), -4);
        chk("mc neg cls", b_cls, 1);
        chk("mc neg result", b_result, 0);

        wbuf[0] = 1; wbuf[1] = 1; wbuf[2] = 0; wbuf[3] = 0;
        wbuf[4] = 1; wbuf[5] = 1; wbuf[6] = 0; wbuf[7] = 0;
        b_loadw(8);
        xbuf[0] = 1; xbuf[1] = 1; xbuf[2] = 0;
        b_start = 1'b1;
        b_feed(3);
        b_wait(lat);
        chk("tie score", $signed(b_score), 2);
        chk("tie cls", b_cls, 0);
        chk("tie result", b_result, 1);

        for (int i = 0; i < 11; i++) xbuf[i] = -2;
        a_start = 1'b1;
        a_feed(11);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("abort ready", a_ready, 1);
        chk("abort wvalid", a_wvalid, 0);
        chk("abort done", a_done, 0);
        chk("abort result", a_result, 0);
        chk("abort cls", a_cls, 0);
        chk("abort score", a_score, 0);
        @(negedge clk) rst = 1'b1;
        a_nodone(20, "abort no done");
        a_feed(11);
        chk("post rst w2 ready", a_ready, 1);
        chk("post rst w2 wvalid", a_wvalid, 0);
        a_nodone(20, "post rst w2 no done");

        for (int i = 0; i < 11; i++) wbuf[i] = 1;
        wbuf[11] = -3;
        a_loadw(12, -1);
        for (int i = 0; i < 11; i++) xbuf[i] = (i < 5) ? 1 : 0;
        xbuf[5] = -1;
        a_feed(11);
        a_wait(lat);
        chk("reload latency", lat, 13);
        chk("reload score", $signed(a_score), 1);
        chk("reload result", a_result, 1);

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
